// File: rtl/connect_four_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// connect_four_pkg: shared direction codes, player encodings, board defaults.
// Rev 1.0
// ----------------------------------------------------------------------------
package connect_four_pkg;

    localparam int DEFAULT_COLS = 7;
    localparam int DEFAULT_ROWS = 6;

    typedef enum logic [3:0] {
        DOWN             = 4'd1,
        ROW_1            = 4'd2,
        ROW_2            = 4'd3,
        ROW_3            = 4'd4,
        ROW_4            = 4'd5,
        DIAG_RIGHT_UP_1  = 4'd6,
        DIAG_RIGHT_UP_2  = 4'd7,
        DIAG_RIGHT_UP_3  = 4'd8,
        DIAG_RIGHT_UP_4  = 4'd9,
        DIAG_LEFT_DOWN_1 = 4'd10,
        DIAG_LEFT_DOWN_2 = 4'd11,
        DIAG_LEFT_DOWN_3 = 4'd12,
        DIAG_LEFT_DOWN_4 = 4'd13
    } direction_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        P1   = 2'b01,
        P2   = 2'b10
    } player_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } scan_state_t;

    // Window w (0..3) spans w-3..w relative to the anchor; the anchor itself is skipped.
    function automatic logic signed [3:0] window_offset(input logic [1:0] window,
                                                        input logic [1:0] idx);
        logic signed [3:0] v;
        v = $signed({2'b00, window}) + $signed({2'b00, idx}) - 4'sd3;
        if (!v[3]) v = v + 4'sd1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/direction_in_bounds.sv
`default_nettype none
// ----------------------------------------------------------------------------
// direction_in_bounds: checks that all three cells of a direction lie on the board.
// Rev 1.0
// ----------------------------------------------------------------------------
module direction_in_bounds
    import connect_four_pkg::*;
#(
    parameter int COLS = DEFAULT_COLS,
    parameter int ROWS = DEFAULT_ROWS
) (
    input  logic [2:0] row,
    input  logic [2:0] col,
    input  logic [3:0] direction,
    output logic       in_bounds
);

    localparam logic [2:0] MAX_ROW = 3'(ROWS - 1);
    localparam logic [2:0] MAX_COL = 3'(COLS - 1);

    logic [1:0]        window;
    logic              use_row;
    logic              use_col;
    logic              neg_col;
    logic              legal;
    logic signed [3:0] off;
    logic signed [3:0] r_pos;
    logic signed [3:0] c_pos;

    always_comb begin
        // Codes 2..13 map onto windows 0..3 by adding 2 modulo 4.
        window  = direction[1:0] + 2'd2;
        use_row = 1'b0;
        use_col = 1'b0;
        neg_col = 1'b0;
        legal   = 1'b1;
        if (direction == DOWN) begin
            use_row = 1'b1;
            window  = 2'd0;
        end else if (direction >= ROW_1 && direction <= ROW_4) begin
            use_col = 1'b1;
        end else if (direction >= DIAG_RIGHT_UP_1 && direction <= DIAG_RIGHT_UP_4) begin
            use_row = 1'b1;
            use_col = 1'b1;
        end else if (direction >= DIAG_LEFT_DOWN_1 && direction <= DIAG_LEFT_DOWN_4) begin
            use_row = 1'b1;
            use_col = 1'b1;
            neg_col = 1'b1;
        end else begin
            legal = 1'b0;
        end

        in_bounds = legal;
        off   = '0;
        r_pos = '0;
        c_pos = '0;
        for (int k = 0; k < 3; k++) begin
            off   = window_offset(window, 2'(k));
            r_pos = $signed({1'b0, row}) + (use_row ? off : 4'sd0);
            c_pos = $signed({1'b0, col}) + (use_col ? (neg_col ? -off : off) : 4'sd0);
            if (r_pos[3] || (r_pos[2:0] > MAX_ROW) || c_pos[3] || (c_pos[2:0] > MAX_COL))
                in_bounds = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/win_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// win_scanner: sequences the 13 line directions through an external checker.
// WIN_SCANNER_EARLY_EXIT_EN stops at the first winning line. Rev 1.0
// ----------------------------------------------------------------------------
module win_scanner
    import connect_four_pkg::*;
#(
    parameter int COLS = DEFAULT_COLS,
    parameter int ROWS = DEFAULT_ROWS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       check_start,
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic       busy,
    output logic       done,
    output logic [1:0] winner,
    output logic       chk_start,
    output logic [2:0] chk_row,
    output logic [2:0] chk_col,
    output logic [3:0] chk_direction,
    input  logic       chk_finished,
    input  logic [1:0] chk_winner
);

    scan_state_t state;
    scan_state_t state_next;
    logic        in_bounds;
    logic        last_dir;

    direction_in_bounds #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_bounds (
        .row      (chk_row),
        .col      (chk_col),
        .direction(chk_direction),
        .in_bounds(in_bounds)
    );

    assign last_dir = (chk_direction == DIAG_LEFT_DOWN_4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (check_start) state_next = SELECT;
            SELECT: begin
                if (in_bounds)     state_next = WAIT;
                else if (last_dir) state_next = DONE;
            end
            WAIT: begin
                if (chk_finished) begin
                    if (last_dir) state_next = DONE;
`ifdef WIN_SCANNER_EARLY_EXIT_EN
                    else if (chk_winner != NONE) state_next = DONE;
`endif
                    else state_next = SELECT;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == SELECT) || (state == WAIT);
        done      = (state == DONE);
        chk_start = (state == SELECT) && in_bounds;
    end

    // Anchor, direction and result registers; they hold across the checker handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_row       <= '0;
            chk_col       <= '0;
            chk_direction <= '0;
            winner        <= NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (check_start) begin
                        chk_row       <= row;
                        chk_col       <= col;
                        chk_direction <= DOWN;
                        winner        <= NONE;
                    end
                end
                SELECT: begin
                    if (!in_bounds && !last_dir) chk_direction <= chk_direction + 4'd1;
                end
                WAIT: begin
                    if (chk_finished) begin
                        if (chk_winner != NONE && winner == NONE) winner <= chk_winner;
                        if (!last_dir) chk_direction <= chk_direction + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_win_scanner.sv
`default_nettype none
// Randomized scoreboard bench for win_scanner with a behavioural checker and line model.
module tb_win_scanner;

    localparam int COLS = 7;
    localparam int ROWS = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       check_start = 1'b0;
    logic [2:0] row = '0;
    logic [2:0] col = '0;
    logic       busy;
    logic       done;
    logic [1:0] winner;
    logic       chk_start;
    logic [2:0] chk_row;
    logic [2:0] chk_col;
    logic [3:0] chk_direction;
    logic       chk_finished = 1'b0;
    logic [1:0] chk_winner = '0;

    win_scanner #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .check_start  (check_start),
        .row          (row),
        .col          (col),
        .busy         (busy),
        .done         (done),
        .winner       (winner),
        .chk_start    (chk_start),
        .chk_row      (chk_row),
        .chk_col      (chk_col),
        .chk_direction(chk_direction),
        .chk_finished (chk_finished),
        .chk_winner   (chk_winner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int board[8][8];
    int exp_dir[$];
    int exp_r[$];
    int exp_c[$];
    int exp_win[$];
    int last_win = 0;
    int max_gap = 5;
    bit in_flight = 1'b0;
    int fl_r, fl_c, fl_d;

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // A direction is a 4-cell line along vector (vr,vc) starting s steps from the anchor.
    function automatic void geom(int d, output int vr, output int vc, output int s);
        if (d == 1)      begin vr = 1; vc = 0;  s = -3;     end
        else if (d <= 5) begin vr = 0; vc = 1;  s = d - 5;  end
        else if (d <= 9) begin vr = 1; vc = 1;  s = d - 9;  end
        else             begin vr = 1; vc = -1; s = d - 13; end
    endfunction

    function automatic bit line_ok(int r, int c, int d);
        int vr, vc, s, rr, cc;
        if (d < 1 || d > 13) return 1'b0;
        geom(d, vr, vc, s);
        for (int k = 0; k < 4; k++) begin
            rr = r + (s + k) * vr;
            cc = c + (s + k) * vc;
            if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int line_player(int r, int c, int d);
        int vr, vc, s, p;
        geom(d, vr, vc, s);
        p = board[r + s * vr][c + s * vc];
        for (int k = 1; k < 4; k++)
            if (board[r + (s + k) * vr][c + (s + k) * vc] != p) return 0;
        return p;
    endfunction

    function automatic void clear_board();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) board[i][j] = 0;
    endfunction

    task automatic push_expect(int r, int c);
        int w = 0;
        for (int d = 1; d <= 13; d++) begin
            if (line_ok(r, c, d)) begin
                exp_dir.push_back(d);
                exp_r.push_back(r);
                exp_c.push_back(c);
                if (w == 0) w = line_player(r, c, d);
`ifdef WIN_SCANNER_EARLY_EXIT_EN
                if (w != 0) break;
`endif
            end
        end
        exp_win.push_back(w);
        last_win = w;
    endtask

    task automatic pulse_start(int r, int c);
        @(posedge clk); #1;
        check_start = 1'b1;
        row = 3'(r);
        col = 3'(c);
        @(posedge clk); #1;
        check_start = 1'b0;
    endtask

    task automatic wait_done(string tag);
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == 2000) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout: done=0 required a done pulse", tag);
        end
        @(negedge clk);
        check({tag, "_done_width"}, int'(done), 0);
        repeat (2) @(negedge clk);
        check({tag, "_winner_hold"}, int'(winner), last_win);
    endtask

    task automatic scan(int r, int c, string tag);
        push_expect(r, c);
        pulse_start(r, c);
        wait_done(tag);
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_winner"}, int'(winner), 0);
        check({tag, "_chk_start"}, int'(chk_start), 0);
        check({tag, "_chk_row"}, int'(chk_row), 0);
        check({tag, "_chk_col"}, int'(chk_col), 0);
        check({tag, "_chk_direction"}, int'(chk_direction), 0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_start) begin
                if (exp_dir.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_chk_start: direction %0d required none", chk_direction);
                end else begin
                    check("chk_direction", int'(chk_direction), exp_dir.pop_front());
                    check("chk_row", int'(chk_row), exp_r.pop_front());
                    check("chk_col", int'(chk_col), exp_c.pop_front());
                end
                check("busy_during_scan", int'(busy), 1);
                in_flight = 1'b1;
                fl_r = chk_row;
                fl_c = chk_col;
                fl_d = chk_direction;
            end
            if (chk_finished && in_flight) begin
                check("stable_row", int'(chk_row), fl_r);
                check("stable_col", int'(chk_col), fl_c);
                check("stable_dir", int'(chk_direction), fl_d);
                in_flight = 1'b0;
            end
            if (done) begin
                if (exp_win.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done: done=1 required 0");
                end else begin
                    check("winner", int'(winner), exp_win.pop_front());
                    check("starts_remaining", exp_dir.size(), 0);
                end
            end
        end
    end

    // Behavioural line checker: answers each start after a random gap.
    initial begin
        int r, c, d, res, gap;
        forever begin
            @(negedge clk);
            if (rst_n && chk_start) begin
                r = chk_row;
                c = chk_col;
                d = chk_direction;
                res = line_ok(r, c, d) ? line_player(r, c, d) : 0;
                gap = $urandom_range(1, max_gap);
                repeat (gap) @(posedge clk);
                #1;
                chk_finished = 1'b1;
                chk_winner = 2'(res);
                @(posedge clk); #1;
                chk_finished = 1'b0;
                chk_winner = '0;
            end
        end
    end

    initial begin
        int k, d, r0, c0, vr, vc, s, p;
        clear_board();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("no_start_after_reset", int'(chk_start), 0);

        // Empty board, corner anchor
        scan(0, 0, "corner_empty");

        // Horizontal P1 line on the bottom row
        clear_board();
        for (int j = 0; j < 4; j++) board[0][j] = 1;
        scan(0, 3, "row_p1");

        // Rising diagonal for P2
        clear_board();
        for (int j = 0; j < 4; j++) board[j][j] = 2;
        scan(2, 2, "diag_p2");

        // Opposite corner
        clear_board();
        scan(5, 6, "far_corner");

        // check_start while busy is ignored
        clear_board();
        push_expect(2, 3);
        pulse_start(2, 3);
        repeat (3) @(posedge clk);
        #1 check_start = 1'b1; row = 3'd1; col = 3'd1;
        @(posedge clk); #1 check_start = 1'b0;
        wait_done("busy_ignore");

        // Reset while waiting on the checker; its late answer must be ignored
        clear_board();
        for (int j = 0; j < 4; j++) board[0][j] = 1;
        max_gap = 5;
        push_expect(0, 3);
        pulse_start(0, 3);
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (chk_start) break;
        end
        if (k == 200) begin
            checks++;
            fails++;
            $display("FAIL reset_scan_timeout: chk_start=0 required 1");
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        exp_dir.delete();
        exp_r.delete();
        exp_c.delete();
        exp_win.delete();
        in_flight = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("late_finish_winner", int'(winner), 0);
        check("late_finish_busy", int'(busy), 0);
        scan(0, 3, "after_reset");

        // Randomized boards and anchors
        for (int t = 0; t < 25; t++) begin
            clear_board();
            max_gap = $urandom_range(1, 5);
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    board[i][j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            r0 = $urandom_range(0, ROWS - 1);
            c0 = $urandom_range(0, COLS - 1);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom_range(1, 13);
                if (line_ok(r0, c0, d)) begin
                    geom(d, vr, vc, s);
                    p = $urandom_range(1, 2);
                    for (int m = 0; m < 4; m++) board[r0 + (s + m) * vr][c0 + (s + m) * vc] = p;
                end
            end
            scan(r0, c0, "random");
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
